// File: rtl/fifo_4.sv
// fifo_4: single-clock 4 x 8-bit FIFO for the SSP TX/RX byte queues.
// Popped data appears on a registered output one edge after the read is accepted.
module fifo_4 #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write,
    input  logic              read,
    input  logic [DWIDTH-1:0] write_d,
    output logic [DWIDTH-1:0] read_d,
    output logic              empty,
    output logic              full
);

    localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH + 1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count;
    logic              push_ok;
    logic              pop_ok;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign pop_ok  = read && !empty;
    assign push_ok = write && (!full || pop_ok);

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // define which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= write_d;
        end
    end

    // NOTE: non-blocking assignments let a simultaneous push and pop on a full
    // FIFO read the old word at rd_ptr while the new word lands in that slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            read_d <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                read_d <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_4.sv
// Self-checking bench for fifo_4: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       write = 1'b0;
    logic       read  = 1'b0;
    logic [7:0] write_d = 8'h00;
    logic [7:0] read_d;
    logic       empty;
    logic       full;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: plain queue of stored bytes plus last popped byte.
    logic [7:0] model_q[$];
    logic [7:0] model_rd = 8'h00;

    fifo_4 dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .write   (write),
        .read    (read),
        .write_d (write_d),
        .read_d  (read_d),
        .empty   (empty),
        .full    (full)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            model_q.delete();
            model_rd = 8'h00;
        end else begin
            bit pop_ok;
            bit push_ok;
            pop_ok  = read && (model_q.size() > 0);
            push_ok = write && (model_q.size() < 4 || pop_ok);
            if (pop_ok)  model_rd = model_q.pop_front();
            if (push_ok) model_q.push_back(write_d);
        end
    end

    // Outputs only move on clk/rst edges, so the falling edge is a quiet sample point.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("model_read_d", 32'(read_d), 32'(model_rd));
            check("model_empty",  32'(empty),  32'(model_q.size() == 0));
            check("model_full",   32'(full),   32'(model_q.size() == 4));
        end
    end

    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        write   = w;
        read    = r;
        write_d = d;
        @(negedge clk_i);
    endtask

    task automatic pulse_reset();
        #2 rst_i = 1'b1;
        #1;
        check("rst_empty",  32'(empty),  32'd1);
        check("rst_full",   32'(full),   32'd0);
        check("rst_read_d", 32'(read_d), 32'h00);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        logic [7:0] fill_vals [4];
        logic [7:0] wrap_exp  [6];
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        wrap_exp  = '{8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2};

        #50;
        check("reset_empty",  32'(empty),  32'd1);
        check("reset_full",   32'(full),   32'd0);
        check("reset_read_d", 32'(read_d), 32'h00);
        #3 rst_i = 1'b0;

        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, fill_vals[i]);
            check("fill_empty", 32'(empty), 32'd0);
            check("fill_full",  32'(full),  32'(i == 3));
        end

        cycle(1'b1, 1'b0, 8'h55);
        check("overflow_full", 32'(full), 32'd1);
        check("overflow_size", 32'(model_q.size()), 32'd4);

        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("drain_read_d", 32'(read_d), 32'(fill_vals[i]));
            check("drain_full",   32'(full),   32'd0);
            check("drain_empty",  32'(empty),  32'(i == 3));
        end

        cycle(1'b0, 1'b1, 8'h00);
        check("underflow_read_d", 32'(read_d), 32'h44);
        check("underflow_empty",  32'(empty),  32'd1);

        cycle(1'b1, 1'b1, 8'h99);
        check("rw_empty_read_d", 32'(read_d), 32'h44);
        check("rw_empty_size",   32'(model_q.size()), 32'd1);
        cycle(1'b0, 1'b1, 8'h00);
        check("rw_empty_drain", 32'(read_d), 32'h99);

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hA1 + 8'(i));
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 8'hB0 + 8'(i));
            check("wrap_read_d", 32'(read_d), 32'(wrap_exp[i]));
            check("wrap_empty",  32'(empty),  32'd0);
            check("wrap_full",   32'(full),   32'd0);
        end
        pulse_reset();

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
        cycle(1'b1, 1'b1, 8'hD0);
        check("full_rw_read_d", 32'(read_d), 32'hC0);
        check("full_rw_full",   32'(full),   32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("full_rw_order", 32'(read_d), (i == 3) ? 32'hD0 : 32'(8'hC1 + 8'(i)));
        end

        for (int i = 0; i < 2000; i++) begin
            int bias;
            bias = (i / 250) % 3;
            cycle($urandom_range(0, 3) < (bias == 0 ? 3 : 1),
                  $urandom_range(0, 3) < (bias == 1 ? 3 : (bias == 0 ? 1 : 2)),
                  8'($urandom));
            if ($urandom_range(0, 149) == 0) pulse_reset();
        end

        cycle(1'b0, 1'b0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
